// File: rtl/piso_pkg.sv
// Shared constants and helpers for the parallel-in/serial-out shift register.
// Pure declarations: no logic, no latency, no flow control.
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 4;

    // Width of a counter that must hold every value 0..width inclusive.
    function automatic int piso_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_shift_reg_if.sv
// Parallel word in, serial bit out, plus framing (valid, remaining-bit count).
// Wires only: no latency; the serial side has no backpressure (one bit per clock).
interface piso_shift_reg_if
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
);
    localparam int CNT_W = piso_cnt_w(WIDTH);

    logic [WIDTH-1:0] pi;
    logic             load;
    logic             so;
    logic             so_valid;
    logic [CNT_W-1:0] bits_left;

    // master: parallel source plus serial consumer; slave: the shift register.
    modport master (
        output pi,
        output load,
        input  so,
        input  so_valid,
        input  bits_left
    );

    modport slave (
        input  pi,
        input  load,
        output so,
        output so_valid,
        output bits_left
    );

endinterface

// File: rtl/piso_shift_reg.sv
// Captures a WIDTH-bit word on load and serialises it one bit per clock, MSB or LSB first.
// Latency: first bit on so the cycle after the load edge; no backpressure, a new load aborts the word.
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    piso_shift_reg_if.slave  bus
);

    localparam int               CNT_W    = piso_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Shifting never stops: once the word is gone, zeros keep flowing and cnt rests at 0.
    always_comb begin
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        if (bus.load) begin
            shreg_nxt = bus.pi;
            cnt_nxt   = CNT_LOAD;
        end else begin
            if (MSB_FIRST) begin
                shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
            end
            if (cnt != '0) begin
                cnt_nxt = cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            shreg <= shreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Outputs decode registered state only, so pi/load never reach so combinationally.
    assign bus.so        = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign bus.so_valid  = (cnt != '0);
    assign bus.bits_left = cnt;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed, table-driven bench for piso_shift_reg: a WIDTH=4 MSB-first instance and a WIDTH=8 LSB-first one.
module tb_piso_shift_reg;
    import piso_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    piso_shift_reg_if #(.WIDTH(4)) b4 ();
    piso_shift_reg_if #(.WIDTH(8)) b8 ();

    piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    piso_shift_reg #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    typedef struct {
        string      name;
        logic       load;
        logic [3:0] pi;
        logic       exp_so;
        logic       exp_valid;
        logic [2:0] exp_bits;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input string name, input logic ld, input logic [3:0] p,
                       input logic so, input logic vld, input logic [2:0] bl);
        vec_t v;
        v.name      = name;
        v.load      = ld;
        v.pi        = p;
        v.exp_so    = so;
        v.exp_valid = vld;
        v.exp_bits  = bl;
        vecs.push_back(v);
    endtask

    task automatic tick_check4(input string name, input logic ld, input logic [3:0] p,
                               input logic so, input logic vld, input logic [2:0] bl);
        @(negedge clk);
        b4.load = ld;
        b4.pi   = p;
        @(posedge clk);
        #1;
        check({name, ".so"},        32'(b4.so),        32'(so));
        check({name, ".so_valid"},  32'(b4.so_valid),  32'(vld));
        check({name, ".bits_left"}, 32'(b4.bits_left), 32'(bl));
    endtask

    initial begin
        logic [7:0] word;

        // Expected values below are worked out by hand from the behaviour of a 4-bit MSB-first PISO.
        // Stream of frames: each is load + 4 shifts, serial 1101 0 1011 0 1100 0 1101 0.
        add("f1_ld", 1, 4'b1101, 1, 1, 3'd4);
        add("f1_s1", 0, 4'bxxxx, 1, 1, 3'd3);
        add("f1_s2", 0, 4'bxxxx, 0, 1, 3'd2);
        add("f1_s3", 0, 4'bxxxx, 1, 1, 3'd1);
        add("f1_s4", 0, 4'b0000, 0, 0, 3'd0);
        add("f2_ld", 1, 4'b1011, 1, 1, 3'd4);
        add("f2_s1", 0, 4'b0000, 0, 1, 3'd3);
        add("f2_s2", 0, 4'b0000, 1, 1, 3'd2);
        add("f2_s3", 0, 4'b0000, 1, 1, 3'd1);
        add("f2_s4", 0, 4'b0000, 0, 0, 3'd0);
        add("f3_ld", 1, 4'b1100, 1, 1, 3'd4);
        add("f3_s1", 0, 4'b1111, 1, 1, 3'd3);
        add("f3_s2", 0, 4'b1111, 0, 1, 3'd2);
        add("f3_s3", 0, 4'b1111, 0, 1, 3'd1);
        add("f3_s4", 0, 4'b1111, 0, 0, 3'd0);
        add("f4_ld", 1, 4'b1101, 1, 1, 3'd4);
        add("f4_s1", 0, 4'b0000, 1, 1, 3'd3);
        add("f4_s2", 0, 4'b0000, 0, 1, 3'd2);
        add("f4_s3", 0, 4'b0000, 1, 1, 3'd1);
        add("f4_s4", 0, 4'b0000, 0, 0, 3'd0);
        // Load mid-word: old bits dropped, count restarts at 4.
        add("mid_ld1", 1, 4'b1101, 1, 1, 3'd4);
        add("mid_s1",  0, 4'b0000, 1, 1, 3'd3);
        add("mid_ld2", 1, 4'b0010, 0, 1, 3'd4);
        add("mid_s2",  0, 4'b0000, 0, 1, 3'd3);
        add("mid_s3",  0, 4'b0000, 1, 1, 3'd2);
        add("mid_s4",  0, 4'b0000, 0, 1, 3'd1);
        add("mid_s5",  0, 4'b0000, 0, 0, 3'd0);
        // Idle after exhaustion: 10 shifts, count must not underflow.
        add("idle_ld", 1, 4'b1111, 1, 1, 3'd4);
        add("idle_s1", 0, 4'b0000, 1, 1, 3'd3);
        add("idle_s2", 0, 4'b0000, 1, 1, 3'd2);
        add("idle_s3", 0, 4'b0000, 1, 1, 3'd1);
        for (int i = 4; i <= 10; i++) add($sformatf("idle_s%0d", i), 0, 4'b0000, 0, 0, 3'd0);
        // Back-to-back loads: head bit of the latest word each cycle.
        add("b2b_ld1", 1, 4'b0111, 0, 1, 3'd4);
        add("b2b_ld2", 1, 4'b1000, 1, 1, 3'd4);
        add("b2b_ld3", 1, 4'b0100, 0, 1, 3'd4);
        add("b2b_s1",  0, 4'b0000, 1, 1, 3'd3);

        b4.load = 1'b0;
        b4.pi   = '0;
        b8.load = 1'b0;
        b8.pi   = '0;

        // Reset state, with a clock edge seen while reset is held.
        #12;
        check("rst4.so",        32'(b4.so),        32'd0);
        check("rst4.so_valid",  32'(b4.so_valid),  32'd0);
        check("rst4.bits_left", 32'(b4.bits_left), 32'd0);
        check("rst8.so",        32'(b8.so),        32'd0);
        check("rst8.so_valid",  32'(b8.so_valid),  32'd0);
        check("rst8.bits_left", 32'(b8.bits_left), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            tick_check4(vecs[i].name, vecs[i].load, vecs[i].pi,
                        vecs[i].exp_so, vecs[i].exp_valid, vecs[i].exp_bits);
        end

        // LSB-first, WIDTH=8: A5 serialises as 1,0,1,0,0,1,0,1.
        word = 8'hA5;
        @(negedge clk);
        b4.load = 1'b0;
        b8.load = 1'b1;
        b8.pi   = word;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("lsb%0d.so", i),        32'(b8.so),        (i < 8) ? 32'(word[i[2:0]]) : 32'd0);
            check($sformatf("lsb%0d.so_valid", i),  32'(b8.so_valid),  (i < 8) ? 32'd1 : 32'd0);
            check($sformatf("lsb%0d.bits_left", i), 32'(b8.bits_left), (i < 8) ? 32'(8 - i) : 32'd0);
            @(negedge clk);
            b8.load = 1'b0;
            b8.pi   = 8'hxx;
        end

        // Asynchronous reset mid-cycle with a word in flight (shreg=1010, cnt=3).
        tick_check4("pre_rst_ld", 1, 4'b1101, 1, 1, 3'd4);
        tick_check4("pre_rst_s1", 0, 4'b0000, 1, 1, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.so",        32'(b4.so),        32'd0);
        check("arst.so_valid",  32'(b4.so_valid),  32'd0);
        check("arst.bits_left", 32'(b4.bits_left), 32'd0);

        // Reset must dominate a load across a clock edge.
        @(negedge clk);
        b4.load = 1'b1;
        b4.pi   = 4'b1111;
        @(posedge clk);
        #1;
        check("rst_ovr.so",        32'(b4.so),        32'd0);
        check("rst_ovr.so_valid",  32'(b4.so_valid),  32'd0);
        check("rst_ovr.bits_left", 32'(b4.bits_left), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        b4.load = 1'b0;

        tick_check4("post_rst_ld", 1, 4'b1001, 1, 1, 3'd4);
        tick_check4("post_rst_s1", 0, 4'b0000, 0, 1, 3'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
